// File: rtl/lbm_pkg.sv
// Shared types and sizing helpers for the LBM step sequencer slice.
package lbm_pkg;

    // Sequencer states; the numeric values are exported unchanged on phase_out.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLIDE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_STREAM  = 2'd3
    } lbm_state_e;

    localparam int PHASE_W      = 2;
    localparam int COORD_W      = 16;
    localparam int STEP_W       = 16;

    // Default lattice and pipeline geometry.
    localparam int DEF_GRID_W      = 256;
    localparam int DEF_GRID_H      = 144;
    localparam int DEF_BRAM_LAT    = 2;
    localparam int DEF_COLLIDE_LAT = 3;
    localparam int DEF_N           = DEF_GRID_W * DEF_GRID_H;
    localparam int DEF_WB_DELAY    = DEF_BRAM_LAT + DEF_COLLIDE_LAT;

    // Number of lattice cells in one sweep.
    function automatic int lbm_cells(input int grid_w, input int grid_h);
        return grid_w * grid_h;
    endfunction

    // Cycles between a read address and its matching write-back.
    function automatic int lbm_wb_delay(input int bram_lat, input int collide_lat);
        return bram_lat + collide_lat;
    endfunction

endpackage

// File: rtl/lbm_addr_delay.sv
// Fixed-depth valid+data shift register used to align write-back strobes
// with the collision datapath latency. Never stalls.
module lbm_addr_delay #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid [DEPTH];
    logic [WIDTH-1:0] r_data  [DEPTH];

    // Shift valid and data one stage per cycle; reset flushes every stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= {WIDTH{1'b0}};
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/lbm_step_sequencer.sv
// Phase sequencer for the LBM core: collision sweep, write-back drain and
// handshaked streaming, repeated for a programmable number of time steps.
module lbm_step_sequencer
    import lbm_pkg::*;
#(
    parameter int GRID_W      = 256,
    parameter int GRID_H      = 144,
    parameter int BRAM_LAT    = 2,
    parameter int COLLIDE_LAT = 3,
    parameter int ADDR_W      = $clog2(GRID_W * GRID_H)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [15:0]       steps_in,
    input  logic              stop_in,
    output logic              rd_valid_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [15:0]       x_out,
    output logic [15:0]       y_out,
    output logic              boundary_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              stream_start_out,
    input  logic              stream_done_in,
    output logic [1:0]        phase_out,
    output logic              busy_out,
    output logic [15:0]       step_count_out,
    output logic              done_out
);

    localparam int N        = lbm_cells(GRID_W, GRID_H);
    localparam int WB_DELAY = lbm_wb_delay(BRAM_LAT, COLLIDE_LAT);
    localparam int DRAIN_W  = (WB_DELAY > 1) ? $clog2(WB_DELAY) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N - 1);
    localparam logic [15:0]        LAST_X     = 16'(GRID_W - 1);
    localparam logic [15:0]        LAST_Y     = 16'(GRID_H - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WB_DELAY - 1);

    // Registered state and outputs
    lbm_state_e         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic               r_rd_valid;
    logic               r_boundary;
    logic               r_stream_start;
    logic               r_done;
    logic               r_busy;
    logic [15:0]        r_step_cnt;
    logic [15:0]        r_steps;
    logic               r_stop_pending;
    logic [DRAIN_W-1:0] r_drain_cnt;

    // Next-state values
    lbm_state_e         w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [15:0]        w_x_nxt;
    logic [15:0]        w_y_nxt;
    logic               w_rd_valid_nxt;
    logic               w_boundary_nxt;
    logic               w_stream_start_nxt;
    logic               w_done_nxt;
    logic [15:0]        w_step_cnt_nxt;
    logic [15:0]        w_steps_nxt;
    logic               w_stop_nxt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic [15:0]        w_step_inc;
    logic               w_last_step;

    assign w_step_inc  = r_step_cnt + 16'd1;
    assign w_last_step = (r_steps != 16'd0) && (w_step_inc == r_steps);

    // Next-state and output decode for the phase sequencer.
    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_x_nxt            = r_x;
        w_y_nxt            = r_y;
        w_rd_valid_nxt     = 1'b0;
        w_stream_start_nxt = 1'b0;
        w_done_nxt         = 1'b0;
        w_step_cnt_nxt     = r_step_cnt;
        w_steps_nxt        = r_steps;
        w_stop_nxt         = r_stop_pending | stop_in;
        w_drain_nxt        = r_drain_cnt;

        case (r_state)
            ST_IDLE: begin
                // A stop request only means something once a run is active.
                w_stop_nxt = 1'b0;
                if (start_in) begin
                    w_state_nxt    = ST_COLLIDE;
                    w_addr_nxt     = {ADDR_W{1'b0}};
                    w_x_nxt        = 16'd0;
                    w_y_nxt        = 16'd0;
                    w_rd_valid_nxt = 1'b1;
                    w_step_cnt_nxt = 16'd0;
                    w_steps_nxt    = steps_in;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_COLLIDE: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = {DRAIN_W{1'b0}};
                end else begin
                    w_rd_valid_nxt = 1'b1;
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    if (r_x == LAST_X) begin
                        w_x_nxt = 16'd0;
                        w_y_nxt = r_y + 16'd1;
                    end else begin
                        w_x_nxt = r_x + 16'd1;
                    end
                end
            end

            ST_DRAIN: begin
                // Hold off streaming until the last write-back has left the pipe.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt        = ST_STREAM;
                    w_stream_start_nxt = 1'b1;
                end else begin
                    w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
                end
            end

            ST_STREAM: begin
                if (stream_done_in) begin
                    w_step_cnt_nxt = w_step_inc;
                    if (w_last_step || r_stop_pending || stop_in) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt    = ST_COLLIDE;
                        w_addr_nxt     = {ADDR_W{1'b0}};
                        w_x_nxt        = 16'd0;
                        w_y_nxt        = 16'd0;
                        w_rd_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase

        w_boundary_nxt = w_rd_valid_nxt &&
                         ((w_x_nxt == 16'd0) || (w_x_nxt == LAST_X) ||
                          (w_y_nxt == 16'd0) || (w_y_nxt == LAST_Y));
    end

    // State and registered-output update; reset aborts any run immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= ST_IDLE;
            r_addr         <= {ADDR_W{1'b0}};
            r_x            <= 16'd0;
            r_y            <= 16'd0;
            r_rd_valid     <= 1'b0;
            r_boundary     <= 1'b0;
            r_stream_start <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_step_cnt     <= 16'd0;
            r_steps        <= 16'd0;
            r_stop_pending <= 1'b0;
            r_drain_cnt    <= {DRAIN_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_rd_valid     <= w_rd_valid_nxt;
            r_boundary     <= w_boundary_nxt;
            r_stream_start <= w_stream_start_nxt;
            r_done         <= w_done_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_step_cnt     <= w_step_cnt_nxt;
            r_steps        <= w_steps_nxt;
            r_stop_pending <= w_stop_nxt;
            r_drain_cnt    <= w_drain_nxt;
        end
    end

    // Write-back strobe/address alignment with the BRAM + collide latency.
    lbm_addr_delay #(
        .DEPTH (WB_DELAY),
        .WIDTH (ADDR_W)
    ) u_wb_delay (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_valid (r_rd_valid),
        .i_data  (r_addr),
        .o_valid (wr_en_out),
        .o_data  (wr_addr_out)
    );

    assign rd_valid_out     = r_rd_valid;
    assign rd_addr_out      = r_addr;
    assign x_out            = r_x;
    assign y_out            = r_y;
    assign boundary_out     = r_boundary;
    assign stream_start_out = r_stream_start;
    assign phase_out        = r_state;
    assign busy_out         = r_busy;
    assign step_count_out   = r_step_cnt;
    assign done_out         = r_done;

endmodule
